// File: rtl/ga_issue_arbiter.sv
// ga_issue_arbiter: round-robin sharing of one ga_coprocessor among NumReq requesters,
// one op outstanding, WAIT watchdog. Optional perf counters under macro GA_ARB_PERF_EN.
package ga_pkg;

    localparam logic [3:0] GA_FUNCT_ADD = 4'd0;
    localparam logic [3:0] GA_FUNCT_SUB = 4'd1;
    localparam logic [3:0] GA_FUNCT_MUL = 4'd2;
    localparam logic [3:0] GA_FUNCT_DOT = 4'd3;

    typedef struct packed {
        logic        valid;
        logic [3:0]  funct;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } ga_req_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        error;
        logic [31:0] result;
    } ga_resp_t;

endpackage

module ga_issue_arbiter
    import ga_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 1023
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  ga_req_t [NumReq-1:0]        req_i,
    output logic [NumReq-1:0]           resp_valid_o,
    input  logic [NumReq-1:0]           resp_ready_i,
    output ga_resp_t                    resp_o,
    output ga_req_t                     cop_req_o,
    input  ga_resp_t                    cop_resp_i,
    output logic                        busy_o,
    output logic [$clog2(NumReq)-1:0]   grant_idx_o,
    output logic                        timeout_o,
    output logic [31:0]                 perf_issued_o,
    output logic [15:0]                 perf_timeouts_o
);

    localparam int GW = $clog2(NumReq);
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TimeoutCycles - 1);
    localparam ga_resp_t TimeoutResp = '{valid: 1'b0, busy: 1'b0, error: 1'b1, result: '0};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   winner;
    ga_req_t         req_q;
    ga_req_t         req_sel;
    ga_resp_t        resp_q;
    logic [TW-1:0]   timer;
    logic            grant;
    logic            timeout;
    logic            resp_done;

    // First requester at or after last+1, wrapping; returns last when nothing is valid.
    function automatic logic [GW-1:0] pick_next(input logic [NumReq-1:0] valid,
                                                input logic [GW-1:0]     last);
        logic [GW-1:0] pick;
        logic [GW-1:0] pos;
        logic          found;
        pick  = last;
        pos   = '0;
        found = 1'b0;
        for (int i = 1; i <= NumReq; i++) begin
            pos = GW'((int'(last) + i) % NumReq);
            if (!found && valid[pos]) begin
                pick  = pos;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        winner        = pick_next(req_valid_i, last_grant);
        req_sel       = req_i[winner];
        req_sel.valid = 1'b0;
        next_state    = state;
        grant         = 1'b0;
        timeout       = 1'b0;
        resp_done     = 1'b0;
        case (state)
            IDLE: begin
                // rst_ni gate keeps req_ready_o at zero while reset is held
                if (rst_ni && (|req_valid_i) && !cop_resp_i.busy) begin
                    grant      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (cop_resp_i.valid) begin
                    next_state = RESP;
                end else if (timer == TimerLast) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i[grant_idx]) begin
                    resp_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_grant <= GW'(NumReq - 1);
            grant_idx  <= '0;
            req_q      <= '0;
            resp_q     <= '0;
            timer      <= '0;
        end else begin
            state <= next_state;
            if (grant) begin
                req_q     <= req_sel;
                grant_idx <= winner;
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT && !cop_resp_i.valid && timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (state == WAIT) begin
                if (cop_resp_i.valid) begin
                    resp_q <= cop_resp_i;
                end else if (timeout) begin
                    resp_q <= TimeoutResp;
                end
            end
            if (resp_done) begin
                last_grant <= grant_idx;
            end
        end
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        if (grant) begin
            req_ready_o[winner] = 1'b1;
        end
        if (state == RESP) begin
            resp_valid_o[grant_idx] = 1'b1;
        end
        // Payload fields stay on the bus through WAIT; only valid is confined to ISSUE.
        cop_req_o       = req_q;
        cop_req_o.valid = (state == ISSUE);
    end

    assign busy_o      = (state != IDLE);
    assign grant_idx_o = grant_idx;
    assign timeout_o   = timeout;
    assign resp_o      = resp_q;

`ifdef GA_ARB_PERF_EN
    logic [31:0] issued_cnt;
    logic [15:0] timeout_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state == ISSUE && issued_cnt != '1) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if (timeout && timeout_cnt != '1) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

    assign perf_issued_o   = issued_cnt;
    assign perf_timeouts_o = timeout_cnt;
`else
    assign perf_issued_o   = '0;
    assign perf_timeouts_o = '0;
`endif

endmodule
